ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage. It consumes the operation class and operand values registered by the ID/EX stage register and returns a 32-bit result to the EX result mux. While an M-extension instruction sits in EX, it raises a stall so the hazard logic holds the ID/EX load and the upstream stages. One operation is in flight at a time.

---
 rtl/ex_muldiv_pkg.sv | 39 +++
 rtl/ex_muldiv_if.sv | 34 +++
 rtl/ex_muldiv_abs_sign.sv | 40 ++++
 rtl/ex_muldiv.sv | 207 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg
// Shared types and constants for the EX-stage RV32M multiply/divide unit.
//   muldiv_funct3_t : RV32M funct3 encodings
//   muldiv_state_t  : sequencer states (IDLE, CALC, FIX, DONE)
//   MULDIV_ITER     : iterations per operation (one bit per edge)
package ex_muldiv_pkg;

  localparam int MULDIV_ITER = 32;
  localparam int CNT_W       = $clog2(MULDIV_ITER);

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // funct3[2] splits the multiply group from the divide group.
  function automatic logic is_div_op(input muldiv_funct3_t f);
    return f[2];
  endfunction

  // Within the divide group funct3[1] selects the remainder.
  function automatic logic is_rem_op(input muldiv_funct3_t f);
    return f[2] & f[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if
// Connection between the EX stage (master) and the multiply/divide unit (slave).
//   op_valid, funct3, rs1_data, rs2_data, flush : EX stage -> unit
//   stall, busy, done, result                   : unit -> EX stage
//
// Handshake: the EX stage holds op_valid, funct3 and both operands steady for
// as long as stall is high. The unit pulses done for one cycle with result
// valid; stall = op_valid & ~done drops in that same cycle, so the ID/EX
// register loads on the edge that ends the done cycle. flush squashes the
// operation in flight and may be raised in any state; op_valid may only drop
// mid-operation together with flush.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            op_valid;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output op_valid, funct3, rs1_data, rs2_data, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  op_valid, funct3, rs1_data, rs2_data, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/ex_muldiv_abs_sign.sv
// ex_muldiv_abs_sign
// Combinational operand conditioning for the multiply/divide unit.
//   funct3  : operation, decides which operands are signed
//   a, b    : raw operands
//   abs_a   : |a| (a itself when a is treated as unsigned)
//   abs_b   : |b| (b itself when b is treated as unsigned)
//   sign_a  : a is signed and negative (sign of the remainder)
//   neg_res : product/quotient must be negated after iterating
module ex_muldiv_abs_sign
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  muldiv_funct3_t  funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] abs_a,
  output logic [XLEN-1:0] abs_b,
  output logic            sign_a,
  output logic            neg_res
);
  logic a_signed;
  logic b_signed;
  logic sign_b;
  logic div_by_zero;

  assign a_signed = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  assign b_signed = funct3 inside {F3_MULH, F3_DIV, F3_REM};

  assign sign_a = a_signed & a[XLEN-1];
  assign sign_b = b_signed & b[XLEN-1];

  assign abs_a = sign_a ? (~a + 1'b1) : a;
  assign abs_b = sign_b ? (~b + 1'b1) : b;

  // A zero divisor leaves an all-ones quotient from the iteration; it must
  // not be negated so the slow path also returns all ones.
  assign div_by_zero = is_div_op(funct3) & (b == '0);
  assign neg_res     = (sign_a ^ sign_b) & ~div_by_zero;
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv
// Iterative RV32M multiply/divide unit in the EX stage. One operation in flight.
// Multiply: radix-2 shift-add, divide: restoring shift-subtract, one bit per
// edge for MULDIV_ITER edges, then one FIX edge for sign correction and word
// selection. Divide-by-zero and signed overflow optionally bypass iteration.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   mif       : slave side of ex_muldiv_if (op/operands/flush in,
//               stall/busy/done/result out)
//   dbg_state : current sequencer state
//   dbg_count : current iteration counter
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  ex_muldiv_if.slave       mif,
  output muldiv_state_t    dbg_state,
  output logic [CNT_W-1:0] dbg_count
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULDIV_ITER - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] count_q;
  muldiv_funct3_t   op_q;
  logic             neg_q;
  logic             sign_a_q;
  logic [XLEN-1:0]  mag_b_q;
  // Shared accumulator. Multiply: {partial product high, remaining multiplier}.
  // Divide: {partial remainder, dividend bits shifting into quotient bits}.
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   result_q;

  muldiv_funct3_t  f3_in;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            sign_a, neg_res;
  logic            start;
  logic            special;
  logic            b_zero;
  logic            ovf;
  logic [XLEN-1:0] special_result;

  assign f3_in = muldiv_funct3_t'(mif.funct3);

  ex_muldiv_abs_sign #(.XLEN(XLEN)) u_abs_sign (
    .funct3  (f3_in),
    .a       (mif.rs1_data),
    .b       (mif.rs2_data),
    .abs_a   (abs_a),
    .abs_b   (abs_b),
    .sign_a  (sign_a),
    .neg_res (neg_res)
  );

  // Special cases are decided from the live operands while still in IDLE.
  assign b_zero  = (mif.rs2_data == '0);
  assign ovf     = (f3_in inside {F3_DIV, F3_REM}) &&
                   (mif.rs1_data == INT_MIN) && (mif.rs2_data == '1);
  assign special = FAST_SPECIAL && is_div_op(f3_in) && (b_zero || ovf);

  always_comb begin
    special_result = '0;
    if (b_zero) begin
      special_result = is_rem_op(f3_in) ? mif.rs1_data : '1;
    end else begin
      special_result = is_rem_op(f3_in) ? '0 : INT_MIN;
    end
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mif.op_valid && !mif.flush) begin
          start   = 1'b1;
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (mif.flush) begin
          state_d = IDLE;
        end else if (count_q == LAST_CNT) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = mif.flush ? IDLE : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- iteration step ----------------
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    // Add the multiplicand when the current multiplier bit is set, then
    // shift the whole accumulator right by one (carry lands in the top bit).
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    mul_next = {add_sum, acc_q[XLEN-1:1]};
    // Shift the next dividend bit into the remainder and trial-subtract;
    // a borrow means the divisor did not fit and the old value is kept.
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    if (div_diff[XLEN]) begin
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // ---------------- sign fix-up and word select ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  always_comb begin
    prod_fix   = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix    = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix    = sign_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    fix_result = '0;
    case (op_q)
      F3_MUL:                       fix_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_result = quo_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      op_q     <= F3_MUL;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q  <= '0;
            op_q     <= f3_in;
            neg_q    <= neg_res;
            sign_a_q <= sign_a;
            mag_b_q  <= abs_b;
            acc_q    <= {{XLEN{1'b0}}, abs_a};
            if (special) begin
              result_q <= special_result;
            end
          end
        end
        CALC: begin
          if (mif.flush) begin
            count_q <= '0;
          end else begin
            acc_q   <= is_div_op(op_q) ? div_next : mul_next;
            count_q <= (count_q == LAST_CNT) ? '0 : count_q + 1'b1;
          end
        end
        FIX: begin
          if (!mif.flush) begin
            result_q <= fix_result;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign mif.busy   = (state_q != IDLE);
  assign mif.done   = (state_q == DONE);
  assign mif.stall  = mif.op_valid & ~mif.done;
  assign mif.result = result_q;
  assign dbg_state  = state_q;
  assign dbg_count  = count_q;

  // Operands must stay presented while iterating unless the op is squashed.
  a_op_held: assert property (@(posedge clk) disable iff (!rst)
    (state_q == CALC || state_q == FIX) |-> (mif.op_valid || mif.flush));

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) mif ();
  muldiv_state_t dbg_state;
  logic [4:0]    dbg_count;

  ex_muldiv #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .mif       (mif),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic written from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] a32, b32;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    a32 = a;
    b32 = b;
    up  = {32'b0, a} * {32'b0, b};
    case (f)
      3'd0: return up[31:0];
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * ub; return sp[63:32]; end
      3'd3: return up[63:32];
      3'd4: return a32 / b32;
      3'd5: return a / b;
      3'd6: return a32 % b32;
      default: return a % b;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Presents one op, counts stall-high cycles until done, checks the result
  // against the scoreboard and the return to IDLE afterwards.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string tag);
    int          stall_cyc;
    int          waited;
    logic [31:0] exp_v;
    @(negedge clk);
    mif.op_valid = 1'b1;
    mif.funct3   = f;
    mif.rs1_data = a;
    mif.rs2_data = b;
    exp_q.push_back(exp_res);
    #1;
    stall_cyc = 0;
    waited    = 0;
    while (mif.done !== 1'b1 && waited < 100) begin
      if (mif.stall === 1'b1) stall_cyc++;
      waited++;
      @(negedge clk);
      #1;
    end
    check({tag, "_done_seen"}, {31'b0, mif.done}, 32'd1);
    check({tag, "_stall_cycles"}, stall_cyc, exp_lat);
    check({tag, "_stall_low_at_done"}, {31'b0, mif.stall}, 32'd0);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check({tag, "_result"}, mif.result, exp_v);
    end else begin
      check({tag, "_sb_nonempty"}, exp_q.size(), 32'd1);
      exp_v = 32'hx;
    end
    mif.op_valid = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'b0, mif.done}, 32'd0);
    check({tag, "_idle_after"}, {31'b0, mif.busy}, 32'd0);
    check({tag, "_result_hold"}, mif.result, exp_v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          pulses;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    mif.op_valid = 1'b0;
    mif.funct3   = 3'd0;
    mif.rs1_data = '0;
    mif.rs2_data = '0;
    mif.flush    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",   {31'b0, mif.busy}, 32'd0);
    check("rst_done",   {31'b0, mif.done}, 32'd0);
    check("rst_result", mif.result, 32'd0);
    check("rst_state",  32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;

    // Multiply group
    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7xm3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh_m1");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 34, "mulhsu_m1x2");

    // Divide group
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 34, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 34, "rem_m7_2");
    run_op(3'd5, 32'd100,       32'd7,  32'd14,        34, "divu_100_7");
    run_op(3'd7, 32'd100,       32'd7,  32'd2,         34, "remu_100_7");

    // Fast path specials
    run_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
    run_op(3'd6, 32'd5,         32'd0,         32'd5,         1, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");

    // Random ops against the arithmetic model
    for (int i = 0; i < 6; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if (rb == 32'd0) rb = 32'd1;
      if ((rf == 3'd4 || rf == 3'd6) && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      run_op(rf, ra, rb, model(rf, ra, rb), 34, "rand");
    end

    // Flush at counter 10: squashed, no done pulse
    @(negedge clk);
    mif.op_valid = 1'b1;
    mif.funct3   = 3'd0;
    mif.rs1_data = 32'h0000_1234;
    mif.rs2_data = 32'h0000_0777;
    repeat (11) @(negedge clk);
    #1;
    check("flush_pre_state", 32'(dbg_state), 32'(CALC));
    check("flush_pre_count", {27'b0, dbg_count}, 32'd10);
    mif.flush    = 1'b1;
    mif.op_valid = 1'b0;
    @(negedge clk);
    #1;
    check("flush_state", 32'(dbg_state), 32'(IDLE));
    check("flush_busy",  {31'b0, mif.busy}, 32'd0);
    mif.flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (mif.done === 1'b1) pulses++;
      @(negedge clk);
      #1;
    end
    check("flush_no_done", pulses, 32'd0);
    check("flush_sb_empty", exp_q.size(), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 34, "mul_after_flush");

    // Asynchronous reset at counter 20
    @(negedge clk);
    mif.op_valid = 1'b1;
    mif.funct3   = 3'd0;
    mif.rs1_data = 32'h0000_5678;
    mif.rs2_data = 32'h0000_1234;
    repeat (21) @(negedge clk);
    #1;
    check("rst_pre_count", {27'b0, dbg_count}, 32'd20);
    check("rst_pre_busy",  {31'b0, mif.busy}, 32'd1);
    #2;
    rst          = 1'b0;
    mif.op_valid = 1'b0;
    #1;
    check("arst_busy",   {31'b0, mif.busy}, 32'd0);
    check("arst_done",   {31'b0, mif.done}, 32'd0);
    check("arst_result", mif.result, 32'd0);
    check("arst_state",  32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    run_op(3'd4, 32'd9, 32'd3, 32'd3, 34, "div_after_rst");

    check("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
